// File: rtl/vcve2_pkg.sv
// Shared types for the vector register file access path.
package vcve2_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_LOCK_EX = 2'b01,
    ARB_LOCK_LS = 2'b10
  } arb_state_t;

  typedef enum logic {
    PORT_EX = 1'b0,
    PORT_LS = 1'b1
  } vrf_port_e;

endpackage

// File: rtl/vrf_port_arbiter.sv
// Arbitrates the execute sequencer and load-store unit onto one single-port VRF RAM,
// with round-robin fairness and multi-beat exclusive locks.
module vrf_port_arbiter
  import vcve2_pkg::*;
#(
  parameter int unsigned VLEN      = 128,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_req_i,
  input  logic                 ex_we_i,
  input  logic [AddrWidth-1:0] ex_addr_i,
  input  logic [VLEN-1:0]      ex_wdata_i,
  input  logic                 ex_lock_i,
  input  logic                 ls_req_i,
  input  logic                 ls_we_i,
  input  logic [AddrWidth-1:0] ls_addr_i,
  input  logic [VLEN-1:0]      ls_wdata_i,
  input  logic                 ls_lock_i,
  output logic                 ex_gnt_o,
  output logic                 ls_gnt_o,
  output logic                 ex_rvalid_o,
  output logic                 ls_rvalid_o,
  output logic [VLEN-1:0]      rdata_o,
  output logic                 ram_req_o,
  output logic                 ram_we_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  output logic [VLEN-1:0]      ram_wdata_o,
  input  logic [VLEN-1:0]      ram_rdata_i,
  output logic [1:0]           owner_o
);

  arb_state_t state_q;
  vrf_port_e  rr_q;
  logic       ex_rvalid_q, ls_rvalid_q;

  always_comb begin
    ex_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (ex_req_i && ls_req_i) begin
            ex_gnt_o = (rr_q == PORT_EX);
            ls_gnt_o = (rr_q == PORT_LS);
          end else begin
            ex_gnt_o = ex_req_i;
            ls_gnt_o = ls_req_i;
          end
        end
        ARB_LOCK_EX: ex_gnt_o = ex_req_i;
        ARB_LOCK_LS: ls_gnt_o = ls_req_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_req_o   = ex_gnt_o | ls_gnt_o;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (ex_gnt_o) begin
      ram_we_o    = ex_we_i;
      ram_addr_o  = ex_addr_i;
      ram_wdata_o = ex_wdata_i;
    end else if (ls_gnt_o) begin
      ram_we_o    = ls_we_i;
      ram_addr_o  = ls_addr_i;
      ram_wdata_o = ls_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      rr_q        <= PORT_EX;
      ex_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
    end else begin
      ex_rvalid_q <= ex_gnt_o & ~ex_we_i;
      ls_rvalid_q <= ls_gnt_o & ~ls_we_i;
      if (ex_gnt_o)      rr_q <= PORT_LS;
      else if (ls_gnt_o) rr_q <= PORT_EX;
      unique case (state_q)
        ARB_IDLE: begin
          if (ex_gnt_o && ex_lock_i)      state_q <= ARB_LOCK_EX;
          else if (ls_gnt_o && ls_lock_i) state_q <= ARB_LOCK_LS;
        end
        ARB_LOCK_EX: if (!ex_lock_i) state_q <= ARB_IDLE;
        ARB_LOCK_LS: if (!ls_lock_i) state_q <= ARB_IDLE;
        default:     state_q <= ARB_IDLE;
      endcase
    end
  end

  // A read granted just before reset must not surface while reset is held.
  assign ex_rvalid_o = ex_rvalid_q & rst_ni;
  assign ls_rvalid_o = ls_rvalid_q & rst_ni;
  assign rdata_o     = ram_rdata_i;
  assign owner_o     = state_q;

endmodule
